// File: rtl/pipe_addsub_pkg.sv
// Shared types and constants for the pipelined adder/subtractor.
package pipe_addsub_pkg;

  typedef enum logic {
    ADDSUB_OP_ADD = 1'b0,
    ADDSUB_OP_SUB = 1'b1
  } addsub_op_e;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  // Legal split: at least one stage, no more stages than bits, equal-width segments.
  function automatic bit split_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle for pipe_addsub; master drives operands, slave is the adder.
interface pipe_addsub_if
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_co;
  logic             out_ov;
  logic             out_z;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_co, out_ov, out_z
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_co, out_ov, out_z
  );
endinterface

// File: rtl/pipe_addsub_seg.sv
// addsub_seg: one SEG-bit adder slice with registered sum and carry under a shared enable.
module addsub_seg #(
  parameter int SEG = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_en,
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_ci,
  output logic [SEG-1:0] o_sum,
  output logic           o_co
);
  logic [SEG:0] w_full;
  logic [SEG:0] r_res;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{SEG{1'b0}}, i_ci};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_res <= '0;
    else if (i_en) r_res <= w_full;
  end

  assign o_sum = r_res[SEG-1:0];
  assign o_co  = r_res[SEG];
endmodule

// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor split into STAGES carry segments with valid/ready flow.
// Define PIPE_ADDSUB_FLAGS_EN to build the signed-overflow and zero flags.
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic         clk,
  input  logic         rst_n,
  pipe_addsub_if.slave bus
);
  localparam int SEG = WIDTH / STAGES;

  if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
    $error("pipe_addsub: STAGES must be 1..WIDTH and divide WIDTH evenly");
  end

  logic              w_en;
  logic              w_sub;
  logic [WIDTH-1:0]  w_beff;
  logic              w_cin_eff;
  logic [WIDTH-1:0]  w_sum;
  logic [STAGES-1:0] r_vld;

  assign w_en      = !r_vld[STAGES-1] || bus.out_ready;
  assign w_sub     = (bus.in_sub == ADDSUB_OP_SUB);
  assign w_beff    = w_sub ? ~bus.in_b : bus.in_b;
  assign w_cin_eff = w_sub ? ~bus.in_cin : bus.in_cin;

  // A cycle without a transfer still advances, shifting a bubble into stage 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_vld <= '0;
    else if (w_en) r_vld <= (r_vld << 1) | STAGES'(bus.in_valid);
  end

  // Stage k sees the not-yet-added operand bits [WIDTH-1:k*SEG] and the finished low sum.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [WIDTH-k*SEG-1:0] w_a_up;
    logic [WIDTH-k*SEG-1:0] w_b_up;
    logic                   w_ci;
    logic [SEG-1:0]         w_seg_sum;
    logic                   w_co;
    logic [(k+1)*SEG-1:0]   w_done;

    if (k == 0) begin : g_head
      assign w_a_up = bus.in_a;
      assign w_b_up = w_beff;
      assign w_ci   = w_cin_eff;
      assign w_done = w_seg_sum;
    end else begin : g_body
      logic [WIDTH-k*SEG-1:0] r_a_up;
      logic [WIDTH-k*SEG-1:0] r_b_up;
      logic [k*SEG-1:0]       r_lo;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a_up <= '0;
          r_b_up <= '0;
          r_lo   <= '0;
        end else if (w_en) begin
          r_a_up <= g_stg[k-1].w_a_up[WIDTH-(k-1)*SEG-1:SEG];
          r_b_up <= g_stg[k-1].w_b_up[WIDTH-(k-1)*SEG-1:SEG];
          r_lo   <= g_stg[k-1].w_done;
        end
      end

      assign w_a_up = r_a_up;
      assign w_b_up = r_b_up;
      assign w_ci   = g_stg[k-1].w_co;
      assign w_done = {w_seg_sum, r_lo};
    end

    addsub_seg #(.SEG(SEG)) u_seg (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_en),
      .i_a   (w_a_up[SEG-1:0]),
      .i_b   (w_b_up[SEG-1:0]),
      .i_ci  (w_ci),
      .o_sum (w_seg_sum),
      .o_co  (w_co)
    );
  end

  assign w_sum         = g_stg[STAGES-1].w_done;
  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_vld[STAGES-1];
  assign bus.out_sum   = w_sum;
  assign bus.out_co    = g_stg[STAGES-1].w_co;

`ifdef PIPE_ADDSUB_FLAGS_EN
  logic [STAGES-1:0] r_a_msb;
  logic [STAGES-1:0] r_b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_msb <= '0;
      r_b_msb <= '0;
    end else if (w_en) begin
      r_a_msb <= (r_a_msb << 1) | STAGES'(bus.in_a[WIDTH-1]);
      r_b_msb <= (r_b_msb << 1) | STAGES'(w_beff[WIDTH-1]);
    end
  end

  assign bus.out_ov = (r_a_msb[STAGES-1] == r_b_msb[STAGES-1]) &&
                      (w_sum[WIDTH-1] != r_a_msb[STAGES-1]);
  assign bus.out_z  = ~|w_sum;
`else
  assign bus.out_ov = 1'b0;
  assign bus.out_z  = 1'b0;
`endif
endmodule
